// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : pll_lock_supervisor
//  Purpose  : Control-side companion to sys_pll. Pulses the PLL reset, waits
//             for lock with a timeout, qualifies lock stability, then releases
//             the fabric reset. Loss of lock in RUN re-asserts the fabric reset
//             and restarts the PLL.
//  Ports    : refclk    - free-running board reference clock (also PLL refclk)
//             reset     - synchronous active-high reset
//             extlock   - asynchronous PLL lock, synchronized internally
//             pll_rst   - PLL reset, active-high, registered
//             sys_rst   - fabric reset, active-high, registered
//             locked_ok - high only in RUN
//             fault     - retry limit exhausted (0 when feature disabled)
//             retry_cnt - lock-timeout retries, saturating
//             loss_cnt  - lock-loss events in RUN, saturating
//             state     - RESET_PLL=0 WAIT_LOCK=1 STABLE=2 RUN=3 LOST=4 FAULT=5
//  Options  : PLL_RETRY_LIMIT_EN - define to stop in FAULT after MAX_RETRY
//             timeouts; undefined means unlimited retries and fault tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int GLITCH_CYCLES = 2,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 20,
    parameter int MAX_RETRY     = 7
) (
    input  logic       refclk,
    input  logic       reset,
    input  logic       extlock,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       locked_ok,
    output logic       fault,
    output logic [7:0] retry_cnt,
    output logic [7:0] loss_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
`ifdef PLL_RETRY_LIMIT_EN
        S_LOST      = 3'd4,
        S_FAULT     = 3'd5
`else
        S_LOST      = 3'd4
`endif
    } state_t;

    localparam logic [CNT_W-1:0] c_RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_STB_LAST    = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_GLITCH_LAST = CNT_W'(GLITCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);

    function automatic logic [CNT_W-1:0] f_sat_cnt(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + c_CNT_ONE;
    endfunction

    function automatic logic [7:0] f_sat8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_rst_cnt, r_tmo_cnt, r_stb_cnt, r_low_cnt;
    logic [7:0]             r_retry, r_loss;
    logic                   r_pll_rst, r_sys_rst, r_locked_ok;

    state_t                 w_state_nxt, w_tmo_state;
    logic [CNT_W-1:0]       w_rst_cnt_nxt, w_tmo_cnt_nxt, w_stb_cnt_nxt, w_low_cnt_nxt;
    logic [7:0]             w_retry_nxt, w_loss_nxt, w_tmo_retry;
    logic                   w_lock_s, w_tmo_hit;

    assign w_lock_s  = r_sync[SYNC_STAGES-1];
    // >= keeps a timeout reachable even if a lock drop lands on the last cycle
    assign w_tmo_hit = (r_tmo_cnt >= c_TMO_LAST);

    // Where a lock timeout sends the FSM, and what it does to retry_cnt.
    always_comb begin
        w_tmo_state = S_RESET_PLL;
        w_tmo_retry = f_sat8(r_retry);
`ifdef PLL_RETRY_LIMIT_EN
        if (r_retry == 8'(MAX_RETRY)) begin
            w_tmo_state = S_FAULT;
            w_tmo_retry = r_retry;
        end
`endif
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rst_cnt_nxt = r_rst_cnt;
        w_tmo_cnt_nxt = r_tmo_cnt;
        w_stb_cnt_nxt = r_stb_cnt;
        w_low_cnt_nxt = r_low_cnt;
        w_retry_nxt   = r_retry;
        w_loss_nxt    = r_loss;
        case (r_state)
            S_RESET_PLL: begin
                if (r_rst_cnt >= c_RST_LAST) begin
                    w_state_nxt   = S_WAIT_LOCK;
                    w_rst_cnt_nxt = '0;
                    w_tmo_cnt_nxt = '0;
                end else begin
                    w_rst_cnt_nxt = f_sat_cnt(r_rst_cnt);
                end
            end
            S_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nxt   = S_STABLE;
                    w_stb_cnt_nxt = '0;
                    w_tmo_cnt_nxt = f_sat_cnt(r_tmo_cnt);
                end else if (w_tmo_hit) begin
                    w_state_nxt   = w_tmo_state;
                    w_retry_nxt   = w_tmo_retry;
                    w_rst_cnt_nxt = '0;
                end else begin
                    w_tmo_cnt_nxt = f_sat_cnt(r_tmo_cnt);
                end
            end
            S_STABLE: begin
                if (w_lock_s && (r_stb_cnt >= c_STB_LAST)) begin
                    w_state_nxt   = S_RUN;
                    w_low_cnt_nxt = '0;
                end else if (w_tmo_hit) begin
                    w_state_nxt   = w_tmo_state;
                    w_retry_nxt   = w_tmo_retry;
                    w_rst_cnt_nxt = '0;
                end else if (!w_lock_s) begin
                    // Timeout keeps running so lock chatter cannot stall forever
                    w_state_nxt   = S_WAIT_LOCK;
                    w_tmo_cnt_nxt = f_sat_cnt(r_tmo_cnt);
                end else begin
                    w_stb_cnt_nxt = f_sat_cnt(r_stb_cnt);
                    w_tmo_cnt_nxt = f_sat_cnt(r_tmo_cnt);
                end
            end
            S_RUN: begin
                if (w_lock_s) begin
                    w_low_cnt_nxt = '0;
                end else if (r_low_cnt >= c_GLITCH_LAST) begin
                    w_state_nxt   = S_LOST;
                    w_low_cnt_nxt = '0;
                    w_loss_nxt    = f_sat8(r_loss);
                end else begin
                    w_low_cnt_nxt = f_sat_cnt(r_low_cnt);
                end
            end
            S_LOST: begin
                w_state_nxt   = S_RESET_PLL;
                w_rst_cnt_nxt = '0;
            end
`ifdef PLL_RETRY_LIMIT_EN
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
`endif
            default: begin
                w_state_nxt   = S_RESET_PLL;
                w_rst_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge refclk) begin
        if (reset) begin
            r_sync      <= '0;
            r_state     <= S_RESET_PLL;
            r_rst_cnt   <= '0;
            r_tmo_cnt   <= '0;
            r_stb_cnt   <= '0;
            r_low_cnt   <= '0;
            r_retry     <= '0;
            r_loss      <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_locked_ok <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], extlock};
            r_state     <= w_state_nxt;
            r_rst_cnt   <= w_rst_cnt_nxt;
            r_tmo_cnt   <= w_tmo_cnt_nxt;
            r_stb_cnt   <= w_stb_cnt_nxt;
            r_low_cnt   <= w_low_cnt_nxt;
            r_retry     <= w_retry_nxt;
            r_loss      <= w_loss_nxt;
            // Outputs decoded from next state so they move with state
`ifdef PLL_RETRY_LIMIT_EN
            r_pll_rst   <= (w_state_nxt == S_RESET_PLL) || (w_state_nxt == S_FAULT);
`else
            r_pll_rst   <= (w_state_nxt == S_RESET_PLL);
`endif
            r_sys_rst   <= (w_state_nxt != S_RUN);
            r_locked_ok <= (w_state_nxt == S_RUN);
        end
    end

`ifdef PLL_RETRY_LIMIT_EN
    logic r_fault;
    always_ff @(posedge refclk) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= (w_state_nxt == S_FAULT);
        end
    end
    assign fault = r_fault;
`else
    // Retry limit is not built; keep the parameter referenced.
    logic w_unused_max_retry;
    assign w_unused_max_retry = (MAX_RETRY != 0);
    assign fault = 1'b0;
`endif

    assign pll_rst   = r_pll_rst;
    assign sys_rst   = r_sys_rst;
    assign locked_ok = r_locked_ok;
    assign retry_cnt = r_retry;
    assign loss_cnt  = r_loss;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pll_lock_supervisor
//  Purpose  : Self-checking bench for pll_lock_supervisor: table-driven
//             vectors, hand-written corner sequences and random extlock
//             traffic compared every cycle against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pll_lock_supervisor;

    localparam int RST_C  = 4;
    localparam int TMO_C  = 100;
    localparam int STB_C  = 10;
    localparam int GL_C   = 2;
    localparam int SYN_C  = 2;
    localparam int MAXR_C = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       extlock;
    logic       pll_rst, sys_rst, locked_ok, fault;
    logic [7:0] retry_cnt, loss_cnt;
    logic [2:0] state;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .RST_CYCLES   (RST_C),
        .LOCK_TIMEOUT (TMO_C),
        .STABLE_CYCLES(STB_C),
        .GLITCH_CYCLES(GL_C),
        .SYNC_STAGES  (SYN_C),
        .CNT_W        (20),
        .MAX_RETRY    (MAXR_C)
    ) dut (
        .refclk   (clk),
        .reset    (rst),
        .extlock  (extlock),
        .pll_rst  (pll_rst),
        .sys_rst  (sys_rst),
        .locked_ok(locked_ok),
        .fault    (fault),
        .retry_cnt(retry_cnt),
        .loss_cnt (loss_cnt),
        .state    (state)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // ---------------- behavioural reference model ----------------
    localparam int P_RST = 0, P_WAIT = 1, P_STB = 2, P_RUN = 3, P_LOST = 4, P_FAULT = 5;
    int m_phase, m_in, m_attempt, m_good, m_bad, m_retry, m_loss;
    bit m_pipe[$];

    task automatic model_reset();
        m_phase = P_RST; m_in = 0; m_attempt = 0; m_good = 0; m_bad = 0;
        m_retry = 0; m_loss = 0;
        m_pipe.delete();
        repeat (SYN_C) m_pipe.push_back(1'b0);
    endtask

    task automatic model_timeout();
`ifdef PLL_RETRY_LIMIT_EN
        if (m_retry == MAXR_C) begin
            m_phase = P_FAULT;
            return;
        end
`endif
        if (m_retry < 255) m_retry++;
        m_phase = P_RST; m_in = 0;
    endtask

    task automatic model_step(input bit r, input bit e);
        bit lk;
        if (r) begin
            model_reset();
            return;
        end
        lk = m_pipe.pop_back();      // oldest sample is what the FSM sees
        m_pipe.push_front(e);
        case (m_phase)
            P_RST: begin
                m_in++;
                if (m_in == RST_C) begin m_phase = P_WAIT; m_attempt = 0; end
            end
            P_WAIT: begin
                if (lk) begin m_phase = P_STB; m_good = 0; m_attempt++; end
                else if (m_attempt + 1 >= TMO_C) model_timeout();
                else m_attempt++;
            end
            P_STB: begin
                if (lk && m_good + 1 == STB_C) begin m_phase = P_RUN; m_bad = 0; end
                else if (m_attempt + 1 >= TMO_C) model_timeout();
                else if (!lk) begin m_phase = P_WAIT; m_attempt++; end
                else begin m_good++; m_attempt++; end
            end
            P_RUN: begin
                if (lk) m_bad = 0;
                else begin
                    m_bad++;
                    if (m_bad >= GL_C) begin
                        m_phase = P_LOST;
                        if (m_loss < 255) m_loss++;
                    end
                end
            end
            P_LOST: begin m_phase = P_RST; m_in = 0; end
            default: ;
        endcase
    endtask

    function automatic logic [22:0] model_vec();
        return {3'(m_phase), (m_phase == P_RST) || (m_phase == P_FAULT), m_phase != P_RUN,
                m_phase == P_RUN, m_phase == P_FAULT, 8'(m_retry), 8'(m_loss)};
    endfunction

    // One clock: model follows the DUT edge, then outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        model_step(rst, extlock);
        #1;
        check("model", 32'({state, pll_rst, sys_rst, locked_ok, fault, retry_cnt, loss_cnt}),
              32'(model_vec()));
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim, input string name);
        int k = 0;
        while (state !== s && k < lim) begin tick(); k++; end
        check(name, 32'(state), 32'(s));
    endtask

    typedef struct {
        bit         rst;
        bit         ext;
        int         ncyc;
        logic [2:0] st;
        logic       pll;
        logic       sys;
        logic [7:0] retry;
        logic [7:0] loss;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #5000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // Power-up, lock, stable, RUN, short dip, real loss, recovery.
        tbl[0]  = '{1'b1, 1'b1, 2, 3'd0, 1'b1, 1'b1, 8'd0, 8'd0};
        tbl[1]  = '{1'b0, 1'b1, 3, 3'd0, 1'b1, 1'b1, 8'd0, 8'd0};
        tbl[2]  = '{1'b0, 1'b1, 1, 3'd1, 1'b0, 1'b1, 8'd0, 8'd0};
        tbl[3]  = '{1'b0, 1'b1, 1, 3'd2, 1'b0, 1'b1, 8'd0, 8'd0};
        tbl[4]  = '{1'b0, 1'b1, 9, 3'd2, 1'b0, 1'b1, 8'd0, 8'd0};
        tbl[5]  = '{1'b0, 1'b1, 1, 3'd3, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[6]  = '{1'b0, 1'b0, 1, 3'd3, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[7]  = '{1'b0, 1'b1, 4, 3'd3, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[8]  = '{1'b0, 1'b0, 3, 3'd3, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[9]  = '{1'b0, 1'b1, 1, 3'd4, 1'b0, 1'b1, 8'd0, 8'd1};
        tbl[10] = '{1'b0, 1'b1, 1, 3'd0, 1'b1, 1'b1, 8'd0, 8'd1};
        tbl[11] = '{1'b0, 1'b1, 3, 3'd0, 1'b1, 1'b1, 8'd0, 8'd1};
        tbl[12] = '{1'b0, 1'b1, 1, 3'd1, 1'b0, 1'b1, 8'd0, 8'd1};
        tbl[13] = '{1'b0, 1'b1, 1, 3'd2, 1'b0, 1'b1, 8'd0, 8'd1};
        tbl[14] = '{1'b0, 1'b1, 9, 3'd2, 1'b0, 1'b1, 8'd0, 8'd1};
        tbl[15] = '{1'b0, 1'b1, 1, 3'd3, 1'b0, 1'b0, 8'd0, 8'd1};

        rst = 1'b1; extlock = 1'b1;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].rst; extlock = tbl[i].ext;
            repeat (tbl[i].ncyc) tick();
            check($sformatf("row%0d", i),
                  32'({state, pll_rst, sys_rst, retry_cnt, loss_cnt}),
                  32'({tbl[i].st, tbl[i].pll, tbl[i].sys, tbl[i].retry, tbl[i].loss}));
        end

        // Reset while in RUN (loss_cnt is 1 here)
        rst = 1'b1; tick();
        check("reset_in_run", 32'({state, pll_rst, sys_rst, locked_ok, retry_cnt, loss_cnt}),
              32'({3'd0, 1'b1, 1'b1, 1'b0, 16'd0}));
        rst = 1'b0; extlock = 1'b1;
        wait_state(3'd2, 40, "reach_stable");
        rst = 1'b1; tick();
        check("reset_in_stable", 32'({state, pll_rst, sys_rst, locked_ok, retry_cnt, loss_cnt}),
              32'({3'd0, 1'b1, 1'b1, 1'b0, 16'd0}));

        // No lock at all: periodic PLL re-pulses, retry_cnt climbs
        begin
            int rises = 0, last = 0, sys_low = 0, exp_r;
            logic prev;
            rst = 1'b0; extlock = 1'b0;
            prev = pll_rst;
            for (int c = 1; c <= 3 * (RST_C + TMO_C) + 8; c++) begin
                tick();
                if (!sys_rst) sys_low++;
                if (pll_rst && !prev) begin
                    rises++;
                    exp_r = rises;
`ifdef PLL_RETRY_LIMIT_EN
                    if (exp_r > MAXR_C) exp_r = MAXR_C;
`endif
                    check("retry_at_rise", 32'(retry_cnt), 32'(exp_r));
                    if (rises > 1) check("rise_spacing", 32'(c - last), 32'(RST_C + TMO_C));
                    last = c;
                end
                prev = pll_rst;
            end
            check("rise_count", 32'(rises), 32'd3);
            check("sys_rst_held", 32'(sys_low), 32'd0);
        end

`ifdef PLL_RETRY_LIMIT_EN
        check("fault_entry", 32'({state, fault, pll_rst, retry_cnt}), 32'({3'd5, 1'b1, 1'b1, 8'd2}));
        extlock = 1'b1;
        repeat (50) tick();
        check("fault_sticky", 32'({state, fault, pll_rst, sys_rst}), 32'({3'd5, 1'b1, 1'b1, 1'b1}));
        rst = 1'b1; tick();
        check("fault_reset", 32'({state, fault, retry_cnt}), 32'({3'd0, 1'b0, 8'd0}));
`endif

        // Lock chatter in STABLE: bounded by the timeout from WAIT_LOCK entry
        begin
            int t_wait = -1, t_rst = -1;
            bit seen_run = 1'b0;
            rst = 1'b1; tick(); rst = 1'b0;
            for (int c = 1; c <= 300 && t_rst < 0; c++) begin
                extlock = (c < 8) ? 1'b1 : (((c - 8) / 5) % 2 == 1);
                tick();
                if (state == 3'd3) seen_run = 1'b1;
                if (t_wait < 0 && state == 3'd1) t_wait = c;
                else if (t_wait >= 0 && state == 3'd0) t_rst = c;
            end
            check("chatter_no_run", 32'(seen_run), 32'd0);
            check("chatter_timeout", 32'(t_rst - t_wait), 32'(TMO_C));
            check("chatter_retry", 32'(retry_cnt), 32'd1);
        end

        // Random extlock traffic against the model
        begin
            int cyc = 0, r, n;
            rst = 1'b1; tick(); rst = 1'b0;
            while (cyc < 4000) begin
                r = $urandom_range(0, 99);
                if (r < 2) begin rst = 1'b1; n = 1; end
                else if (r < 10) begin extlock = 1'b0; n = $urandom_range(100, 250); end
                else if (r < 50) begin extlock = 1'b0; n = $urandom_range(1, 4); end
                else begin extlock = 1'b1; n = $urandom_range(1, 60); end
                repeat (n) tick();
                rst = 1'b0;
                cyc += n;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
